// File: rtl/clus_pattern_checker_pkg.sv
// -----------------------------------------------------------------------------
// clus_pattern_checker_pkg
//   Shared definitions for the cluster-pattern stream checker: parser state
//   encoding, header field widths and the header size-to-word-count helper.
// -----------------------------------------------------------------------------
package clus_pattern_checker_pkg;

  // Header size field (hits*2, already truncated by the producer) and the
  // derived payload word count (size*4).
  localparam int SIZE_W  = 12;
  localparam int WORDS_W = 14;

  typedef enum logic {
    ST_HDR = 1'b0,
    ST_PAY = 1'b1
  } parse_state_t;

  // Each size unit stands for four payload words.
  function automatic logic [WORDS_W-1:0] size_to_words(input logic [SIZE_W-1:0] size);
    return {size, 2'b00};
  endfunction

endpackage

// File: rtl/clus_pattern_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   fifoclk        clock
//   fifoclk_reset  asynchronous active-high reset, clears the count
//   inc            add one this cycle (ignored once saturated)
//   count          current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             fifoclk,
  input  logic             fifoclk_reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge fifoclk or posedge fifoclk_reset) begin
    if (fifoclk_reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clus_pattern_checker.sv
// -----------------------------------------------------------------------------
// clus_pattern_checker
//   Parses the simulated cluster-pattern stream (header + payload events) and
//   checks tag continuity, payload length and payload content (counter or
//   alternating 0x55../0xAA.. words). Reports saturating event/error counts,
//   sticky error flags and the word that caused the first error.
// Ports:
//   fifoclk         single clock
//   fifoclk_reset   asynchronous active-high reset
//   newspill_reset  synchronous parser re-arm at spill start (beats the stream)
//   haltrun_en      keep the expected counter across newspill_reset
//   check_type      0 = counter payload, 1 = alternating 0x55../0xAA.. payload
//   pattern_we      stream word valid
//   pattern_data    stream word
//   evt_cnt         completed events (saturating)
//   err_cnt         events with at least one error (saturating)
//   tag_err         sticky: header tag was not previous tag + 1
//   len_err         sticky: event truncated by newspill_reset
//   data_err        sticky: payload word differed from the expected word
//   first_bad_word  header/payload word behind the first tag/data error
// -----------------------------------------------------------------------------
module clus_pattern_checker
  import clus_pattern_checker_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 20,
  parameter int CNT_W  = 16
) (
  input  logic              fifoclk,
  input  logic              fifoclk_reset,
  input  logic              newspill_reset,
  input  logic              haltrun_en,
  input  logic              check_type,
  input  logic              pattern_we,
  input  logic [DATA_W-1:0] pattern_data,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              tag_err,
  output logic              len_err,
  output logic              data_err,
  output logic [DATA_W-1:0] first_bad_word
);

  localparam logic [DATA_W-1:0] ALT_55 = {(DATA_W/2){2'b01}};
  localparam logic [DATA_W-1:0] ALT_AA = {(DATA_W/2){2'b10}};

  parse_state_t state, next_state;

  logic [TAG_W-1:0]   prev_tag;
  logic               tag_valid;
  logic [WORDS_W-1:0] words_left;
  logic [DATA_W-1:0]  exp_cnt;
  logic               exp_alt;
  logic               evt_err;

  logic [TAG_W-1:0]   hdr_tag;
  logic [WORDS_W-1:0] hdr_words;
  logic [TAG_W-1:0]   tag_next;
  logic [DATA_W-1:0]  exp_word;

  logic hdr_word;
  logic pay_word;
  logic tag_bad;
  logic data_bad;
  logic evt_done;
  logic abort;
  logic err_done;

  assign hdr_tag   = pattern_data[TAG_W-1:0];
  assign hdr_words = size_to_words(pattern_data[DATA_W-1 -: SIZE_W]);
  assign tag_next  = prev_tag + TAG_W'(1);
  assign exp_word  = check_type ? (exp_alt ? ALT_AA : ALT_55) : exp_cnt;

  always_ff @(posedge fifoclk or posedge fifoclk_reset) begin
    if (fifoclk_reset) begin
      state <= ST_HDR;
    end else begin
      state <= next_state;
    end
  end

  // newspill_reset always lands the parser back on a header boundary.
  always_comb begin
    next_state = state;
    if (newspill_reset) begin
      next_state = ST_HDR;
    end else if (pattern_we) begin
      case (state)
        ST_HDR:  if (hdr_words != '0) next_state = ST_PAY;
        ST_PAY:  if (words_left == WORDS_W'(1)) next_state = ST_HDR;
        default: next_state = ST_HDR;
      endcase
    end
  end

  // Per-word strobes. A word arriving together with newspill_reset is
  // discarded, so every strobe is qualified by its absence.
  always_comb begin
    hdr_word = 1'b0;
    pay_word = 1'b0;
    tag_bad  = 1'b0;
    data_bad = 1'b0;
    evt_done = 1'b0;
    abort    = 1'b0;
    err_done = 1'b0;
    if (newspill_reset) begin
      abort = (state == ST_PAY);
    end else if (pattern_we) begin
      hdr_word = (state == ST_HDR);
      pay_word = (state == ST_PAY);
    end
    tag_bad  = hdr_word && tag_valid && (hdr_tag != tag_next);
    data_bad = pay_word && (pattern_data != exp_word);
    evt_done = (hdr_word && (hdr_words == '0)) ||
               (pay_word && (words_left == WORDS_W'(1)));
    // An event is charged to err_cnt once, when it closes or is cut short.
    err_done = abort || (evt_done && (evt_err || tag_bad || data_bad));
  end

  // Parser datapath: tag history, payload budget and the expected-word
  // generators. The counter advances on every payload word in both modes
  // and on empty events, so it tracks the producer's hit counter.
  always_ff @(posedge fifoclk or posedge fifoclk_reset) begin
    if (fifoclk_reset) begin
      prev_tag   <= '0;
      tag_valid  <= 1'b0;
      words_left <= '0;
      exp_cnt    <= '0;
      exp_alt    <= 1'b0;
      evt_err    <= 1'b0;
    end else if (newspill_reset) begin
      tag_valid <= 1'b0;
      exp_alt   <= 1'b0;
      evt_err   <= 1'b0;
      if (!haltrun_en) begin
        exp_cnt <= '0;
      end
    end else if (hdr_word) begin
      prev_tag   <= hdr_tag;
      tag_valid  <= 1'b1;
      words_left <= hdr_words;
      evt_err    <= tag_bad && !evt_done;
      if (hdr_words == '0) begin
        exp_cnt <= exp_cnt + DATA_W'(1);
      end
    end else if (pay_word) begin
      words_left <= words_left - WORDS_W'(1);
      exp_cnt    <= exp_cnt + DATA_W'(1);
      evt_err    <= (evt_err || data_bad) && !evt_done;
      if (check_type) begin
        exp_alt <= ~exp_alt;
      end
    end
  end

  // Sticky flags. A truncation has no offending word, so len_err alone
  // never loads first_bad_word, but it does block later loads.
  always_ff @(posedge fifoclk or posedge fifoclk_reset) begin
    if (fifoclk_reset) begin
      tag_err        <= 1'b0;
      len_err        <= 1'b0;
      data_err       <= 1'b0;
      first_bad_word <= '0;
    end else begin
      if ((tag_bad || data_bad) && !tag_err && !len_err && !data_err) begin
        first_bad_word <= pattern_data;
      end
      if (tag_bad) tag_err <= 1'b1;
      if (data_bad) data_err <= 1'b1;
      if (abort) len_err <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_evt_counter (
    .fifoclk       (fifoclk),
    .fifoclk_reset (fifoclk_reset),
    .inc           (evt_done),
    .count         (evt_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_counter (
    .fifoclk       (fifoclk),
    .fifoclk_reset (fifoclk_reset),
    .inc           (err_done),
    .count         (err_cnt)
  );

endmodule

// File: tb/tb_clus_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_clus_pattern_checker
//   Drives directed and randomized header/payload streams into the checker and
//   compares every cycle against an event-level model of the stream rules.
//   Counters are built 4 bits wide so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_clus_pattern_checker;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 20;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] W55 = 32'h5555_5555;
  localparam logic [31:0] WAA = 32'hAAAA_AAAA;

  logic              fifoclk = 1'b0;
  logic              fifoclk_reset = 1'b1;
  logic              newspill_reset = 1'b0;
  logic              haltrun_en = 1'b0;
  logic              check_type = 1'b0;
  logic              pattern_we = 1'b0;
  logic [DATA_W-1:0] pattern_data = '0;
  logic [CNT_W-1:0]  evt_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic              tag_err;
  logic              len_err;
  logic              data_err;
  logic [DATA_W-1:0] first_bad_word;

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 1'b0;

  clus_pattern_checker #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .fifoclk        (fifoclk),
    .fifoclk_reset  (fifoclk_reset),
    .newspill_reset (newspill_reset),
    .haltrun_en     (haltrun_en),
    .check_type     (check_type),
    .pattern_we     (pattern_we),
    .pattern_data   (pattern_data),
    .evt_cnt        (evt_cnt),
    .err_cnt        (err_cnt),
    .tag_err        (tag_err),
    .len_err        (len_err),
    .data_err       (data_err),
    .first_bad_word (first_bad_word)
  );

  always #5 fifoclk = ~fifoclk;

  // Reference model: the stream as a sequence of events, each a header
  // announcing size*4 payload words, tracked with plain integers.
  bit          m_in_event;
  int          m_remaining;
  int unsigned m_prev_tag;
  bit          m_tag_known;
  int unsigned m_next_count;
  int          m_alt_index;
  bit          m_event_bad;
  int          m_events;
  int          m_errors;
  bit          m_tag_err, m_len_err, m_data_err;
  int unsigned m_first_bad;

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic modelReset();
    m_in_event = 0; m_remaining = 0; m_prev_tag = 0; m_tag_known = 0;
    m_next_count = 0; m_alt_index = 0; m_event_bad = 0;
    m_events = 0; m_errors = 0;
    m_tag_err = 0; m_len_err = 0; m_data_err = 0; m_first_bad = 0;
  endtask

  task automatic modelRecordBad(input int unsigned word);
    if (!m_tag_err && !m_len_err && !m_data_err) m_first_bad = word;
  endtask

  task automatic modelCloseEvent();
    m_events = sat_inc(m_events);
    if (m_event_bad) m_errors = sat_inc(m_errors);
    m_in_event = 0;
  endtask

  task automatic modelStep(input bit nsr, input bit halt, input bit ctype,
                           input bit we, input int unsigned word);
    int unsigned tag, words, expect_word;
    if (nsr) begin
      if (m_in_event) begin
        m_len_err = 1;
        m_errors = sat_inc(m_errors);
      end
      m_in_event = 0; m_tag_known = 0; m_alt_index = 0;
      if (!halt) m_next_count = 0;
    end else if (we) begin
      if (!m_in_event) begin
        tag = word % (1 << TAG_W);
        words = (word >> 20) * 4;
        m_event_bad = 0;
        if (m_tag_known && tag != (m_prev_tag + 1) % (1 << TAG_W)) begin
          modelRecordBad(word);
          m_tag_err = 1;
          m_event_bad = 1;
        end
        m_prev_tag = tag; m_tag_known = 1;
        if (words == 0) begin
          m_next_count = m_next_count + 1;
          modelCloseEvent();
        end else begin
          m_in_event = 1;
          m_remaining = int'(words);
        end
      end else begin
        expect_word = ctype ? ((m_alt_index % 2 == 0) ? W55 : WAA) : m_next_count;
        if (word != expect_word) begin
          modelRecordBad(word);
          m_data_err = 1;
          m_event_bad = 1;
        end
        m_next_count = m_next_count + 1;
        if (ctype) m_alt_index = m_alt_index + 1;
        m_remaining = m_remaining - 1;
        if (m_remaining == 0) modelCloseEvent();
      end
    end
  endtask

  always @(posedge fifoclk or posedge fifoclk_reset) begin
    if (fifoclk_reset) modelReset();
    else modelStep(newspill_reset, haltrun_en, check_type, pattern_we, pattern_data);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge fifoclk) begin
    if (check_en && !fifoclk_reset) begin
      checkOutput("evt_cnt", 32'(evt_cnt), 32'(m_events));
      checkOutput("err_cnt", 32'(err_cnt), 32'(m_errors));
      checkOutput("tag_err", 32'(tag_err), 32'(m_tag_err));
      checkOutput("len_err", 32'(len_err), 32'(m_len_err));
      checkOutput("data_err", 32'(data_err), 32'(m_data_err));
      checkOutput("first_bad_word", first_bad_word, m_first_bad);
    end
  end

  // One cycle of stimulus, launched and returned on the falling edge.
  task automatic applyStimulus(input bit we, input logic [31:0] data, input bit nsr);
    pattern_we = we;
    pattern_data = data;
    newspill_reset = nsr;
    @(posedge fifoclk);
    @(negedge fifoclk);
    pattern_we = 1'b0;
    newspill_reset = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] data);
    applyStimulus(1'b1, data, 1'b0);
  endtask

  function automatic logic [31:0] hdr(input int unsigned size, input int unsigned tag);
    return {size[11:0], tag[19:0]};
  endfunction

  task automatic sendCountEvent(input int unsigned tag, input int unsigned size,
                                input int unsigned first);
    sendWord(hdr(size, tag));
    for (int i = 0; i < int'(size) * 4; i++) sendWord(first + i);
  endtask

  task automatic doReset();
    fifoclk_reset = 1'b1;
    pattern_we = 1'b0;
    newspill_reset = 1'b0;
    check_type = 1'b0;
    haltrun_en = 1'b0;
    repeat (2) @(negedge fifoclk);
    fifoclk_reset = 1'b0;
  endtask

  initial begin
    int unsigned gen_tag, gen_cnt, word, sz;
    bit gen_alt;

    // Reset state
    doReset();
    check_en = 1'b1;
    checkOutput("reset_evt_cnt", 32'(evt_cnt), 0);
    checkOutput("reset_first_bad", first_bad_word, 0);

    // Three clean counter events, tags 0..2
    for (int t = 0; t < 3; t++) sendCountEvent(t, 2, t * 8);
    checkOutput("t1_evt_cnt", 32'(evt_cnt), 3);
    checkOutput("t1_err_cnt", 32'(err_cnt), 0);
    checkOutput("t1_flags", {29'd0, tag_err, len_err, data_err}, 0);

    // Empty event advances the expected counter by one
    doReset();
    sendWord(hdr(0, 0));
    sendCountEvent(1, 2, 1);
    checkOutput("t2_evt_cnt", 32'(evt_cnt), 2);
    checkOutput("t2_data_err", 32'(data_err), 0);

    // Corrupted payload words, counted once per event
    doReset();
    sendWord(hdr(2, 0));
    for (int i = 0; i < 8; i++)
      sendWord(i == 5 ? 32'hDEAD_BEEF : (i == 6 ? 32'h1234_5678 : i));
    checkOutput("t3_data_err", 32'(data_err), 1);
    checkOutput("t3_first_bad", first_bad_word, 32'hDEAD_BEEF);
    checkOutput("t3_err_cnt", 32'(err_cnt), 1);

    // Tag gap, then tag wrap
    doReset();
    sendWord(hdr(0, 7));
    sendWord(hdr(0, 9));
    checkOutput("t4_tag_err", 32'(tag_err), 1);
    checkOutput("t4_err_cnt", 32'(err_cnt), 1);
    doReset();
    sendWord(hdr(0, 32'hFFFFF));
    sendWord(hdr(0, 0));
    checkOutput("t4_wrap_tag_err", 32'(tag_err), 0);
    checkOutput("t4_wrap_evt_cnt", 32'(evt_cnt), 2);

    // Alternating payload continuing across events, then a wrong phase
    doReset();
    check_type = 1'b1;
    for (int e = 0; e < 2; e++) begin
      sendWord(hdr(2, e));
      for (int i = 0; i < 8; i++) sendWord((i % 2 == 0) ? W55 : WAA);
    end
    checkOutput("t5_clean_data_err", 32'(data_err), 0);
    sendWord(hdr(2, 2));
    sendWord(WAA);
    checkOutput("t5_phase_data_err", 32'(data_err), 1);
    checkOutput("t5_phase_first_bad", first_bad_word, WAA);

    // Truncated event, haltrun behaviour, asynchronous reset mid-payload
    doReset();
    sendCountEvent(0, 2, 0);
    sendWord(hdr(2, 1));
    for (int i = 8; i < 11; i++) sendWord(i);
    haltrun_en = 1'b1;
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("t6_len_err", 32'(len_err), 1);
    checkOutput("t6_evt_cnt", 32'(evt_cnt), 1);
    checkOutput("t6_err_cnt", 32'(err_cnt), 1);
    sendCountEvent(5, 2, 11);
    checkOutput("t6_halt_data_err", 32'(data_err), 0);
    haltrun_en = 1'b0;
    applyStimulus(1'b0, 0, 1'b1);
    sendCountEvent(9, 2, 0);
    checkOutput("t6_restart_data_err", 32'(data_err), 0);
    checkOutput("t6_restart_evt_cnt", 32'(evt_cnt), 3);
    sendWord(hdr(2, 10));
    sendWord(0);
    sendWord(1);
    #2 fifoclk_reset = 1'b1;
    #1;
    checkOutput("t6_async_evt_cnt", 32'(evt_cnt), 0);
    checkOutput("t6_async_err_cnt", 32'(err_cnt), 0);
    checkOutput("t6_async_flags", {29'd0, tag_err, len_err, data_err}, 0);
    @(negedge fifoclk);
    fifoclk_reset = 1'b0;

    // Randomized mostly-well-formed streams with injected faults
    gen_tag = 0; gen_cnt = 0; gen_alt = 0;
    for (int e = 0; e < 80; e++) begin
      if ($urandom_range(0, 7) == 0) check_type = $urandom_range(0, 1);
      gen_tag = ($urandom_range(0, 7) == 0) ? $urandom : gen_tag + 1;
      sz = $urandom_range(0, 3);
      sendWord(hdr(sz, gen_tag));
      if (sz == 0) gen_cnt++;
      for (int w = 0; w < int'(sz) * 4; w++) begin
        if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, $urandom, 1'b0);
        if ($urandom_range(0, 39) == 0) begin
          haltrun_en = $urandom_range(0, 1);
          applyStimulus($urandom_range(0, 1), $urandom, 1'b1);
          if (!haltrun_en) gen_cnt = 0;
          gen_alt = 0;
          break;
        end
        word = check_type ? (gen_alt ? WAA : W55) : gen_cnt;
        if ($urandom_range(0, 19) == 0) word = word ^ ($urandom | 1);
        sendWord(word);
        gen_cnt++;
        if (check_type) gen_alt = ~gen_alt;
      end
    end
    checkOutput("rand_evt_saturated", 32'(evt_cnt), CNT_MAX);

    @(negedge fifoclk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
